booth_bist_ctrl: RTL

BOOTH_BIST_CTRL -- requirements
Module: booth_bist_ctrl

---
 rtl/booth_bist_pkg.sv | 42 ++++
 rtl/bist_lfsr8.sv | 40 ++++
 rtl/booth_bist_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/booth_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_bist_pkg
// Purpose  : Shared types, constants and helpers for the Booth multiplier
//            BIST controller: the FSM state encoding, the LFSR/MISR tap mask,
//            default parameter values and the shift-register next-state
//            function.
// Revision : 1.0 - initial release
// ============================================================================
package booth_bist_pkg;

    // Controller states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        ARM     = 3'd2,
        WAIT    = 3'd3,
        COMPACT = 3'd4,
        CHECK   = 3'd5,
        FINISH  = 3'd6
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1 in Fibonacci form: feedback is the XOR of
    // register bits 7, 5, 4 and 3.
    localparam logic [7:0] c_lfsr_taps = 8'hB8;

    localparam int         c_def_n_patterns = 16;
    localparam logic [7:0] c_def_lfsr_seed  = 8'hA5;
    localparam logic [7:0] c_def_golden_sig = 8'h00;
    localparam int         c_def_timeout    = 32;

    // One shift step: feedback enters at bit 0, then the parallel word is
    // folded in. With par = 0 this is a plain LFSR, otherwise a MISR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q,
                                             input logic [7:0] par);
        logic fb;
        fb = ^(q & c_lfsr_taps);
        return {q[6:0], fb} ^ par;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : bist_lfsr8
// Purpose  : 8-bit shift register usable as a pattern LFSR (par_in = 0) or
//            as a multiple-input signature register (par_in = data word).
// Ports    : clk    - clock, rising edge
//            rst    - synchronous active-high reset, loads seed
//            load   - load seed
//            seed   - value taken on rst or load
//            step   - advance one step, folding in par_in
//            par_in - parallel data word XORed into the shifted state
//            q      - current register contents
// Revision : 1.0 - initial release
// ============================================================================
module bist_lfsr8
    import booth_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    input  logic [7:0] par_in,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q <= seed;
        end else if (step) begin
            r_q <= lfsr_next(r_q, par_in);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/booth_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_bist_ctrl
// Purpose  : Built-in self test controller for a 4x4 signed Booth multiplier.
//            An LFSR generates operand pairs, each product is compacted into
//            a MISR, and the final signature is compared against a golden
//            value. A per-operation busy timeout ends the run as a failure.
// Ports    : clk         - clock, rising edge
//            rst         - synchronous active-high reset
//            test        - level request, high starts and holds a run
//            mul_busy    - multiplier busy flag
//            mul_product - multiplier signed product
//            mul_a/mul_b - operands to the multiplier
//            mul_start   - one-cycle start pulse
//            done        - run finished (completion or timeout)
//            pass        - signature matched and no timeout
//            signature   - current MISR contents
// Revision : 1.0 - initial release
// ============================================================================
module booth_bist_ctrl
    import booth_bist_pkg::*;
#(
    parameter int         N_PATTERNS = c_def_n_patterns,
    parameter logic [7:0] LFSR_SEED  = c_def_lfsr_seed,
    parameter logic [7:0] GOLDEN_SIG = c_def_golden_sig,
    parameter int         TIMEOUT    = c_def_timeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test,
    input  logic       mul_busy,
    input  logic [7:0] mul_product,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    output logic       mul_start,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    // Wait counter counts 0 .. TIMEOUT-1.
    localparam int c_wait_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t              r_state;
    logic [7:0]          r_pat_cnt;
    logic [c_wait_w-1:0] r_wait_cnt;

    logic       w_load;
    logic       w_step;
    logic       w_abort;
    logic [7:0] w_lfsr_q;
    logic [7:0] w_misr_q;
    logic [7:0] w_lfsr_next;
    logic [8:0] w_pat_next;

    // A dropped request anywhere mid-run returns to IDLE; IDLE and FINISH
    // handle a low request themselves.
    assign w_abort = !test && (r_state != IDLE) && (r_state != FINISH);

    assign w_load      = (r_state == IDLE) && test;
    // Compaction is suppressed on abort so the MISR keeps its value.
    assign w_step      = (r_state == COMPACT) && test;
    assign w_lfsr_next = lfsr_next(w_lfsr_q, 8'h00);
    assign w_pat_next  = {1'b0, r_pat_cnt} + 9'd1;

    bist_lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .seed   (LFSR_SEED),
        .step   (w_step),
        .par_in (8'h00),
        .q      (w_lfsr_q)
    );

    bist_lfsr8 u_misr (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .seed   (8'h00),
        .step   (w_step),
        .par_in (mul_product),
        .q      (w_misr_q)
    );

    assign signature = w_misr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pat_cnt  <= '0;
            r_wait_cnt <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                done    <= 1'b0;
                pass    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (test) begin
                            r_pat_cnt      <= '0;
                            r_wait_cnt     <= '0;
                            // The LFSR loads the seed on this same edge, so
                            // the operands are taken from the seed directly.
                            {mul_a, mul_b} <= LFSR_SEED;
                            mul_start      <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        r_state <= ARM;
                    end
                    ARM: begin
                        r_wait_cnt <= '0;
                        r_state    <= WAIT;
                    end
                    WAIT: begin
                        if (!mul_busy) begin
                            r_state <= COMPACT;
                        end else if (r_wait_cnt == c_wait_w'(TIMEOUT - 1)) begin
                            done    <= 1'b1;
                            pass    <= 1'b0;
                            r_state <= FINISH;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    COMPACT: begin
                        r_pat_cnt <= w_pat_next[7:0];
                        if (w_pat_next < 9'(N_PATTERNS)) begin
                            // LFSR steps on this edge; present its next value.
                            {mul_a, mul_b} <= w_lfsr_next;
                            mul_start      <= 1'b1;
                            r_state        <= ISSUE;
                        end else begin
                            r_state <= CHECK;
                        end
                    end
                    CHECK: begin
                        pass    <= (w_misr_q == GOLDEN_SIG);
                        done    <= 1'b1;
                        r_state <= FINISH;
                    end
                    FINISH: begin
                        if (!test) begin
                            done    <= 1'b0;
                            pass    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // A zero seed would lock the pattern generator at zero.
    a_seed_nonzero: assert property (@(posedge clk) LFSR_SEED != 8'h00)
        else $error("booth_bist_ctrl: LFSR_SEED must be nonzero");

endmodule
`default_nettype wire
